// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS layout, dmem access types and the TX FSM states.
package mmio_pkg;

    localparam logic [2:0] OFS_TXDATA = 3'h0;
    localparam logic [2:0] OFS_STATUS = 3'h4;

    localparam int ST_FULL_BIT = 0;
    localparam int ST_IDLE_BIT = 1;
    localparam int ST_OVF_BIT  = 2;
    localparam int ST_CNT_LSB  = 8;

    localparam logic [2:0] TYP_B  = 3'b001;
    localparam logic [2:0] TYP_H  = 3'b010;
    localparam logic [2:0] TYP_W  = 3'b011;
    localparam logic [2:0] TYP_BU = 3'b101;
    localparam logic [2:0] TYP_HU = 3'b110;
    localparam logic [2:0] TYP_WU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic logic [31:0] pack_status(input logic full, input logic idle,
                                                input logic ovf, input logic [7:0] cnt);
        logic [31:0] s;
        s                          = '0;
        s[ST_FULL_BIT]             = full;
        s[ST_IDLE_BIT]             = idle;
        s[ST_OVF_BIT]              = ovf;
        s[ST_CNT_LSB+7:ST_CNT_LSB] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Show-ahead synchronous FIFO; rdata is the head entry whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != DEPTH_C) || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// dmem-mapped UART transmitter: window decode, registered response,
// sticky overflow flag and an 8N1 serializer fed from a TX FIFO.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_fcn,
    input  logic [2:0]  req_typ,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int             BW       = $clog2(CLKS_PER_BIT);
    localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          uart_tx_q, tx_busy_q;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          ovf_q, ovf_d;

    logic          hit, push_req, status_rd, pop, drop, baud_last;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_ok;

    // Every access size writes one byte; upper data bits and typ are don't-care.
    assign unused_ok = ^{req_typ, req_data[31:8]};

    assign hit       = req_valid && (req_addr[31:3] == BASE_ADDR[31:3]);
    assign push_req  = hit && req_fcn && (req_addr[2:0] == OFS_TXDATA);
    assign status_rd = hit && !req_fcn && (req_addr[2:0] == OFS_STATUS);
    assign baud_last = (baud_q == BAUD_MAX);
    assign pop       = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_last));
    assign drop      = push_req && fifo_full && !pop;

    assign status = pack_status(fifo_full, fifo_empty && (state_q == IDLE), ovf_q,
                                8'(fifo_count));

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .wdata (req_data[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A drop on the same edge as a STATUS read must leave the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (status_rd) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
        resp_valid_d = hit;
        resp_data_d  = status_rd ? status : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            ovf_q        <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            ovf_q        <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
            tx_busy_q <= 1'b0;
        end else begin
            uart_tx_q <= (state_q == START) ? 1'b0 :
                         (state_q == DATA)  ? shift_q[0] : 1'b1;
            tx_busy_q <= !(fifo_empty && (state_q == IDLE));
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (!fifo_empty) begin
                        shift_q <= fifo_rdata;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) state_q <= STOP;
                        else               bit_q   <= bit_q + 3'd1;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (!fifo_empty) begin
                            shift_q <= fifo_rdata;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign uart_tx    = uart_tx_q;
    assign tx_busy    = tx_busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4;
// a background receiver decodes frames into rxq.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] STAT = 32'h1000_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_fcn;
    logic [2:0]  req_typ;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        uart_tx;
    logic        tx_busy;

    int checks   = 0;
    int failures = 0;
    logic [7:0] rxq[$];

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_fcn    (req_fcn),
        .req_typ    (req_typ),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    // Receiver: start bit seen at frame offset 0, each bit sampled mid-period.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (5) @(negedge clk);
                rxq.push_back(b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic frame_bit(input logic [7:0] b, input int off);
        if (off < 4)  return 1'b0;
        if (off < 36) return b[(off - 4) / 4];
        return 1'b1;
    endfunction

    task automatic idle_bus();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        req_fcn   = 1'b0;
        req_typ   = 3'b011;
    endtask

    task automatic drive(input logic fcn, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] typ);
        req_valid = 1'b1;
        req_fcn   = fcn;
        req_addr  = addr;
        req_data  = data;
        req_typ   = typ;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n >= 1000) begin
            failures++;
            $display("FAIL %s_idle_timeout: tx_busy=%b required 0", name, tx_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_bus();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({uart_tx, resp_valid, tx_busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_outputs: tx/rv/busy=%b required 100", {uart_tx, resp_valid, tx_busy});
        end
        checks++;
        if (resp_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_resp_data: got %h required 00000000", resp_data);
        end
        drive(1'b0, STAT, 32'h0, 3'b011);
        @(negedge clk);
        idle_bus();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0002) begin
            failures++;
            $display("FAIL reset_status: rv=%b data=%h required rv=1 data=00000002", resp_valid, resp_data);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp_pulse: rv=%b required 0", resp_valid);
        end
    endtask

    task automatic test_single();
        logic exp_tx, exp_busy;
        drive(1'b1, BASE, 32'h0000_0055, 3'b011);
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            if (k == 0) begin
                idle_bus();
                checks++;
                if (resp_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL single_store_resp: rv=%b required 1", resp_valid);
                end
            end
            exp_tx   = (k < 2) ? 1'b1 : (k < 42) ? frame_bit(8'h55, k - 2) : 1'b1;
            exp_busy = (k >= 1 && k <= 41);
            checks++;
            if (uart_tx !== exp_tx || tx_busy !== exp_busy) begin
                failures++;
                $display("FAIL single_wave@N+%0d: tx=%b busy=%b required tx=%b busy=%b",
                         k, uart_tx, tx_busy, exp_tx, exp_busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_tx, exp_busy;
        drive(1'b1, BASE, 32'h0000_0048, 3'b011);
        for (int k = 0; k < 86; k++) begin
            @(negedge clk);
            if (k == 0) drive(1'b1, BASE, 32'h0000_0069, 3'b011);
            if (k == 1) idle_bus();
            exp_tx   = (k < 2)  ? 1'b1 :
                       (k < 42) ? frame_bit(8'h48, k - 2) :
                       (k < 82) ? frame_bit(8'h69, k - 42) : 1'b1;
            exp_busy = (k >= 1 && k <= 81);
            checks++;
            if (uart_tx !== exp_tx || tx_busy !== exp_busy) begin
                failures++;
                $display("FAIL b2b_wave@N+%0d: tx=%b busy=%b required tx=%b busy=%b",
                         k, uart_tx, tx_busy, exp_tx, exp_busy);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        rxq.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, BASE, 32'h0000_0010 + i, 3'b011);
            @(negedge clk);
        end
        drive(1'b0, STAT, 32'h0, 3'b011);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0405) begin
            failures++;
            $display("FAIL ovf_status1: rv=%b data=%h required rv=1 data=00000405", resp_valid, resp_data);
        end
        @(negedge clk);
        idle_bus();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0401) begin
            failures++;
            $display("FAIL ovf_status2: rv=%b data=%h required rv=1 data=00000401", resp_valid, resp_data);
        end
        wait_idle("ovf");
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        checks++;
        if (rxq != exp_q) begin
            failures++;
            $display("FAIL ovf_bytes: got %0d bytes %p required %p", rxq.size(), rxq, exp_q);
        end
    endtask

    task automatic test_decode();
        logic [7:0] exp_q[$];
        rxq.delete();
        drive(1'b1, 32'h1000_0008, 32'h0000_0077, 3'b011);
        @(negedge clk);
        drive(1'b0, 32'h0FFF_FFFC, 32'h0, 3'b011);
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL decode_miss_store: rv=%b required 0", resp_valid);
        end
        @(negedge clk);
        drive(1'b0, BASE, 32'h0, 3'b011);
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL decode_miss_load: rv=%b required 0", resp_valid);
        end
        @(negedge clk);
        drive(1'b1, STAT, 32'h0000_00EE, 3'b011);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0) begin
            failures++;
            $display("FAIL decode_txdata_load: rv=%b data=%h required rv=1 data=00000000", resp_valid, resp_data);
        end
        @(negedge clk);
        idle_bus();
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL decode_status_store_resp: rv=%b required 1", resp_valid);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (rxq.size() != 0 || tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL decode_no_tx: bytes=%0d busy=%b required 0 0", rxq.size(), tx_busy);
        end
        drive(1'b1, BASE, 32'hFFFF_FFA5, 3'b001);
        @(negedge clk);
        drive(1'b1, BASE, 32'h0000_1234, 3'b010);
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL decode_sb_resp: rv=%b required 1", resp_valid);
        end
        @(negedge clk);
        idle_bus();
        wait_idle("decode");
        exp_q = '{8'hA5, 8'h34};
        checks++;
        if (rxq != exp_q) begin
            failures++;
            $display("FAIL decode_bytes: got %p required %p", rxq, exp_q);
        end
    endtask

    task automatic test_reset_mid();
        logic went_low;
        drive(1'b1, BASE, 32'h0000_0000, 3'b011);
        @(negedge clk);
        idle_bus();
        repeat (12) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: tx=%b busy=%b required 0 1", uart_tx, tx_busy);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_abort: tx=%b busy=%b rv=%b required 1 0 0", uart_tx, tx_busy, resp_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive(1'b0, STAT, 32'h0, 3'b011);
        @(negedge clk);
        idle_bus();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0002) begin
            failures++;
            $display("FAIL midrst_status: rv=%b data=%h required rv=1 data=00000002", resp_valid, resp_data);
        end
        repeat (60) @(negedge clk);
        rxq.delete();
        went_low = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) went_low = 1'b1;
        end
        checks++;
        if (went_low || rxq.size() != 0) begin
            failures++;
            $display("FAIL midrst_residual: activity=%b bytes=%0d required 0 0", went_low, rxq.size());
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_bus();
        test_reset();
        test_single();
        wait_idle("single");
        test_back_to_back();
        wait_idle("b2b");
        test_overflow();
        test_decode();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
